// File: rtl/demux1ne2_16bit_buf.sv
// Buffered 1-to-2 demultiplexer for 16-bit words with valid/ready handshakes.
// Each accepted word is steered by S into one of two independent FIFO channels.

module demux1ne2_16bit_buf_chan #(
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          push_i,
   input  logic [15:0]   data_i,
   input  logic          pop_i,
   output logic [15:0]   data_o,
   output logic          valid_o,
   output logic          full_o,
   output logic [AW:0]   count_o
);

   localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CONE = 1;
   localparam logic [AW-1:0] PONE = 1;

   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d;
   logic [AW-1:0] wr_q, wr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          empty;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt_q == '0);
   assign full_o  = (cnt_q == FULL);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty;

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (do_push) begin
         wr_d = wr_q + PONE;
      end
      if (do_pop) begin
         rd_d = rd_q + PONE;
      end
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CONE;
         2'b01:   cnt_d = cnt_q - CONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage is left unreset; stale words are masked by the occupancy count.
   always_ff @(posedge Clock) begin
      if (do_push) begin
         mem_q[wr_q] <= data_i;
      end
   end

   assign valid_o = !empty;
   assign data_o  = empty ? 16'h0000 : mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

module demux1ne2_16bit_buf #(
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic [15:0]   Hyrja,
   input  logic          Hyrja_Valid,
   input  logic          S,
   output logic          Hyrja_Gati,
   output logic [15:0]   Dalja0,
   output logic          Valid0,
   input  logic          Gati0,
   output logic [15:0]   Dalja1,
   output logic          Valid1,
   input  logic          Gati1,
   output logic [AW:0]   Numri0,
   output logic [AW:0]   Numri1
);

   if (DEPTH < 2 || DEPTH != (1 << AW)) begin : g_bad_param
      $error("DEPTH must be a power of two >= 2 and equal 2**AW");
   end

   logic full0, full1;
   logic accept;
   logic push0, push1;

   // Ready looks only at the selected channel's current fill, so a pop
   // in the same cycle never frees room for the incoming word.
   assign Hyrja_Gati = S ? !full1 : !full0;
   assign accept     = Hyrja_Valid && Hyrja_Gati;
   assign push0      = accept && !S;
   assign push1      = accept && S;

   demux1ne2_16bit_buf_chan #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ch0 (
      .Clock   (Clock),
      .Reset   (Reset),
      .push_i  (push0),
      .data_i  (Hyrja),
      .pop_i   (Gati0),
      .data_o  (Dalja0),
      .valid_o (Valid0),
      .full_o  (full0),
      .count_o (Numri0)
   );

   demux1ne2_16bit_buf_chan #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ch1 (
      .Clock   (Clock),
      .Reset   (Reset),
      .push_i  (push1),
      .data_i  (Hyrja),
      .pop_i   (Gati1),
      .data_o  (Dalja1),
      .valid_o (Valid1),
      .full_o  (full1),
      .count_o (Numri1)
   );

endmodule

// File: tb/tb_demux1ne2_16bit_buf.sv
// Scoreboard bench for demux1ne2_16bit_buf: queue model per channel,
// directed scenarios followed by randomized traffic.

module tb_demux1ne2_16bit_buf;

   localparam int DEPTH = 2;
   localparam int AW    = 1;

   logic          Clock = 1'b0;
   logic          Reset;
   logic [15:0]   Hyrja;
   logic          Hyrja_Valid;
   logic          S;
   logic          Hyrja_Gati;
   logic [15:0]   Dalja0, Dalja1;
   logic          Valid0, Valid1;
   logic          Gati0, Gati1;
   logic [AW:0]   Numri0, Numri1;

   int total = 0;
   int bad   = 0;

   // m*: behavioural channel contents; e*: words awaiting the monitor
   logic [15:0] m0[$], m1[$];
   logic [15:0] e0[$], e1[$];

   demux1ne2_16bit_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Hyrja       (Hyrja),
      .Hyrja_Valid (Hyrja_Valid),
      .S           (S),
      .Hyrja_Gati  (Hyrja_Gati),
      .Dalja0      (Dalja0),
      .Valid0      (Valid0),
      .Gati0       (Gati0),
      .Dalja1      (Dalja1),
      .Valid1      (Valid1),
      .Gati1       (Gati1),
      .Numri0      (Numri0),
      .Numri1      (Numri1)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_ready(input logic s);
      return s ? (m1.size() < DEPTH) : (m0.size() < DEPTH);
   endfunction

   // Reference model advances on each edge using the pre-edge inputs.
   always @(posedge Clock) begin
      logic take;
      if (!Reset) begin
         take = Hyrja_Valid && model_ready(S);
         if (Gati0 && m0.size() > 0) void'(m0.pop_front());
         if (Gati1 && m1.size() > 0) void'(m1.pop_front());
         if (take) begin
            if (S) begin
               m1.push_back(Hyrja);
               e1.push_back(Hyrja);
            end else begin
               m0.push_back(Hyrja);
               e0.push_back(Hyrja);
            end
         end
      end
   end

   // Monitor: mid-cycle, compare outputs against the scoreboard heads.
   initial begin
      forever begin
         @(negedge Clock);
         if (!Reset) begin
            chk("valid0", {31'b0, Valid0}, {31'b0, e0.size() != 0});
            chk("numri0", 32'(Numri0), 32'(e0.size()));
            if (e0.size() != 0) begin
               chk("dalja0", 32'(Dalja0), 32'(e0[0]));
               if (Gati0) void'(e0.pop_front());
            end else begin
               chk("dalja0_empty", 32'(Dalja0), 32'h0);
            end
            chk("valid1", {31'b0, Valid1}, {31'b0, e1.size() != 0});
            chk("numri1", 32'(Numri1), 32'(e1.size()));
            if (e1.size() != 0) begin
               chk("dalja1", 32'(Dalja1), 32'(e1[0]));
               if (Gati1) void'(e1.pop_front());
            end else begin
               chk("dalja1_empty", 32'(Dalja1), 32'h0);
            end
         end
      end
   end

   task automatic step(input logic v, input logic s, input logic [15:0] d,
                       input logic g0, input logic g1);
      @(posedge Clock);
      #2;
      Hyrja_Valid = v;
      S           = s;
      Hyrja       = d;
      Gati0       = g0;
      Gati1       = g1;
      #1;
      chk("ready", {31'b0, Hyrja_Gati}, {31'b0, model_ready(s)});
   endtask

   task automatic clear_model();
      m0.delete();
      m1.delete();
      e0.delete();
      e1.delete();
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_valid0"}, {31'b0, Valid0}, 32'h0);
      chk({tag, "_valid1"}, {31'b0, Valid1}, 32'h0);
      chk({tag, "_numri0"}, 32'(Numri0), 32'h0);
      chk({tag, "_numri1"}, 32'(Numri1), 32'h0);
      chk({tag, "_dalja0"}, 32'(Dalja0), 32'h0);
      chk({tag, "_dalja1"}, 32'(Dalja1), 32'h0);
   endtask

   initial begin
      Reset       = 1'b1;
      Hyrja       = '0;
      Hyrja_Valid = 1'b0;
      S           = 1'b0;
      Gati0       = 1'b0;
      Gati1       = 1'b0;
      repeat (3) @(posedge Clock);
      #2;
      check_reset_state("rst");
      Reset = 1'b0;

      // single word to channel 0
      step(1, 0, 16'hA5A5, 0, 0);
      step(0, 0, 16'h0000, 0, 0);
      chk("t1_dalja0", 32'(Dalja0), 32'hA5A5);
      chk("t1_numri0", 32'(Numri0), 32'h1);
      chk("t1_valid1", {31'b0, Valid1}, 32'h0);

      // fill channel 1, observe ready drop and recover on S switch
      step(1, 1, 16'h0001, 0, 0);
      step(1, 1, 16'h0002, 0, 0);
      step(1, 1, 16'h0003, 0, 0);
      chk("t2_numri1", 32'(Numri1), 32'h2);
      chk("t2_full_rdy", {31'b0, Hyrja_Gati}, 32'h0);
      step(0, 0, 16'h0000, 0, 0);
      chk("t2_switch_rdy", {31'b0, Hyrja_Gati}, 32'h1);

      // push to full ch1 while popping it: rejected, retry accepted
      step(1, 1, 16'h0003, 0, 1);
      chk("t4_rdy", {31'b0, Hyrja_Gati}, 32'h0);
      step(1, 1, 16'h0003, 0, 0);
      chk("t4_numri1", 32'(Numri1), 32'h1);
      chk("t4_dalja1", 32'(Dalja1), 32'h0002);
      step(0, 0, 16'h0000, 0, 1);
      step(0, 0, 16'h0000, 0, 1);
      step(0, 0, 16'h0000, 0, 1);
      chk("t4_drained", {31'b0, Valid1}, 32'h0);

      // simultaneous push and pop on ch0 holding one word
      step(1, 0, 16'h1234, 1, 0);
      step(0, 0, 16'h0000, 0, 0);
      chk("t3_numri0", 32'(Numri0), 32'h1);
      chk("t3_dalja0", 32'(Dalja0), 32'h1234);
      step(0, 0, 16'h0000, 1, 0);

      // alternate channels, both consumers ready
      for (int i = 0; i < 8; i++) begin
         step(1, i[0], 16'h0010 + 16'(i), 1, 1);
      end
      repeat (3) step(0, 0, 16'h0000, 1, 1);

      // asynchronous reset with data in both channels
      step(1, 0, 16'hC0DE, 0, 0);
      step(1, 1, 16'hBEEF, 0, 0);
      step(0, 0, 16'h0000, 0, 0);
      @(posedge Clock);
      #2;
      Reset = 1'b1;
      clear_model();
      #1;
      check_reset_state("async");
      @(posedge Clock);
      #2;
      Reset = 1'b0;

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom),
              16'($urandom), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 2) != 0));
      end
      repeat (4) step(0, 0, 16'h0000, 1, 1);
      chk("end_e0", 32'(e0.size()), 32'h0);
      chk("end_e1", 32'(e1.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/demux1ne2_16bit_buf.md
Name: demux1ne2_16bit_buf

Overview:
- Buffered 1-to-2 demultiplexer for 16-bit words, with a valid/ready handshake on the input and on both outputs.
- Each accepted input word is steered by select S into one of two independent FIFO channels.
- Sits between a single producer (ALU/bus result) and two consumers (e.g. register-file write port and memory write path), decoupling their stalls.

Parameters:
- DEPTH, 2, entries per output channel FIFO; power of two, minimum 2.
- AW, 1, pointer width = log2(DEPTH); must be set consistently with DEPTH.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Hyrja  input  16  input data word.
- Hyrja_Valid  input  1  producer presents a word on Hyrja.
- S  input  1  destination select: 0 -> channel 0, 1 -> channel 1; sampled with Hyrja.
- Hyrja_Gati  output  1  ready; word accepted on a rising edge when Hyrja_Valid && Hyrja_Gati.
- Dalja0  output  16  channel 0 head word.
- Valid0  output  1  channel 0 non-empty.
- Gati0  input  1  channel 0 consumer ready; pop on a rising edge when Valid0 && Gati0.
- Dalja1  output  16  channel 1 head word.
- Valid1  output  1  channel 1 non-empty.
- Gati1  input  1  channel 1 consumer ready; pop on a rising edge when Valid1 && Gati1.
- Numri0  output  AW+1  channel 0 occupancy, 0..DEPTH.
- Numri1  output  AW+1  channel 1 occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - Read/write pointers and occupancy counts go to 0; Valid0 = Valid1 = 0; Numri0 = Numri1 = 0.
  - Stored words are discarded; memory contents need not be cleared.
  - Dalja0 = Dalja1 = 16'h0000 while the channel is empty.
- Ready:
  - Hyrja_Gati = !full(selected channel). This is combinational from S and the occupancy of the channel S selects.
  - It is independent of Hyrja_Valid and of the pop signals. A pop on a full channel in the same cycle does NOT make room for a push in that cycle.
- Push: on a rising edge with Hyrja_Valid && Hyrja_Gati:
  - Hyrja is written at the write pointer of channel S.
  - That channel's write pointer increments, wrapping modulo DEPTH.
  - The other channel is untouched.
- Pop: on a rising edge with ValidN && GatiN, channel N's read pointer increments, wrapping modulo DEPTH.
- Occupancy update per channel, per edge: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
- Data outputs: DaljaN = mem_N[rd_ptr_N] when NumriN != 0, else 16'h0000. ValidN = (NumriN != 0).
- Latency: a word accepted at edge k is visible on DaljaN with ValidN = 1 immediately after edge k. Input-to-output latency is 1 cycle.
- Ordering: strict FIFO order within each channel. There is no ordering relation between channels.
- Both channels can pop in the same cycle. At most one push per cycle, to one channel.
- Empty channel with a push: the word appears after that edge. No bypass in the same cycle; Valid never rises combinationally.
- Full channel: Hyrja_Gati = 0 while S selects it. Changing S to a non-full channel raises Hyrja_Gati in the same cycle.
- GatiN asserted while ValidN = 0 has no effect; pointers do not move.
- Gati0/Gati1 and Hyrja_Valid with X/undefined outside the handshake are not required to be tolerated; the bench drives known values.

Test Plan:
- Reset, then Hyrja_Valid = 1, S = 0, Hyrja = 16'hA5A5 for 1 cycle, Gati0 = 0 -> next cycle Valid0 = 1, Dalja0 = 16'hA5A5, Numri0 = 1, Valid1 = 0, Dalja1 = 0.
- DEPTH = 2: push 16'h0001 then 16'h0002 to ch1 with Gati1 = 0 -> Numri1 = 2, Hyrja_Gati = 0 while S = 1. Switch S = 0 -> Hyrja_Gati = 1 in the same cycle. Raise Gati1 -> Dalja1 reads 16'h0001, then 16'h0002, then Valid1 = 0.
- Ch0 holding 1 word, Gati0 = 1, simultaneous push of 16'h1234 to ch0 -> Numri0 stays 1; next Dalja0 = 16'h1234.
- Ch1 full, push attempt to ch1 while popping ch1 -> word not accepted; Numri1 drops 2 -> 1; retry next cycle is accepted.
- Alternate S each cycle over 8 words 16'h0010..16'h0017 with both Gati = 1 -> ch0 outputs 0010, 0012, 0014, 0016 and ch1 outputs 0011, 0013, 0015, 0017, in order, with no loss; pointers wrap.
- Assert Reset asynchronously mid-stream with both channels holding data -> Valid0, Valid1, Numri0, Numri1 go to 0 before the next clock edge; Dalja0 and Dalja1 read 16'h0000.
